// File: rtl/qcs_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : qcs_gpio_pkg
// Purpose : Shared types and constants for the GPIO UVC and its driver engine.
//           Holds the driver command opcode and FSM state encodings, the
//           default delay-field width, and the UVC-wide maximum line count.
// Revision: 1.0 - initial release
// ============================================================================
package qcs_gpio_pkg;

  localparam int QCS_GPIO_UVC_MAX_WIDTH = 32;
  localparam int QCS_GPIO_DRV_DLY_W     = 16;

  typedef enum logic [1:0] {
    GPIO_DRV_WRITE = 2'd0,
    GPIO_DRV_SET   = 2'd1,
    GPIO_DRV_CLEAR = 2'd2,
    GPIO_DRV_PULSE = 2'd3
  } gpio_drv_op_e;

  typedef enum logic [1:0] {
    GPIO_DRV_IDLE  = 2'd0,
    GPIO_DRV_WAIT  = 2'd1,
    GPIO_DRV_APPLY = 2'd2,
    GPIO_DRV_HOLD  = 2'd3
  } gpio_drv_state_e;

endpackage : qcs_gpio_pkg
`default_nettype wire

// File: rtl/qcs_gpio_drv_timer.sv
`default_nettype none
// ============================================================================
// Module  : qcs_gpio_drv_timer
// Purpose : DLY_W-bit down-counter shared by the delay and pulse-hold phases.
// Ports   : clk, rst_n      - clock, synchronous active-low reset
//           load, load_val  - load the counter with load_val
//           expire          - count is 1 (last cycle of the interval), or a
//                             load of 1 is being presented
// Revision: 1.0 - initial release
// ============================================================================
module qcs_gpio_drv_timer #(
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  output logic             expire
);

  logic [DLY_W-1:0] r_cnt;

  // Counter parks at zero once spent, so it can never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DLY_W'(1);
    end
  end

  assign expire = (r_cnt == DLY_W'(1)) || (load && (load_val == DLY_W'(1)));

endmodule : qcs_gpio_drv_timer
`default_nettype wire

// File: rtl/qcs_gpio_drv.sv
`default_nettype none
// ============================================================================
// Module  : qcs_gpio_drv
// Purpose : GPIO driver engine. Accepts masked WRITE/SET/CLEAR/PULSE commands
//           over valid/ready, applies them to the registered gpio output after
//           a programmable delay, and returns a one-cycle response carrying
//           the pin state captured at command acceptance.
// Ports   : clk, rst_n                 - clock, synchronous active-low reset
//           cmd_valid / cmd_ready      - command handshake
//           cmd_op/mask/data/delay/len - command payload
//           gpio                       - driven pins (registered)
//           rsp_valid / rsp_prev       - completion pulse, pre-command pins
//           busy                       - command in flight
// Revision: 1.0 - initial release
// ============================================================================
module qcs_gpio_drv
  import qcs_gpio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DLY_W     = QCS_GPIO_DRV_DLY_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  gpio_drv_op_e       cmd_op,
  input  logic [WIDTH-1:0]   cmd_mask,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic [DLY_W-1:0]   cmd_delay,
  input  logic [DLY_W-1:0]   cmd_len,
  output logic [WIDTH-1:0]   gpio,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_prev,
  output logic               busy
);

  generate
    if (WIDTH > QCS_GPIO_UVC_MAX_WIDTH) begin : g_width_check
      $fatal(1, "qcs_gpio_drv: WIDTH exceeds QCS_GPIO_UVC_MAX_WIDTH");
    end
  endgenerate

  gpio_drv_state_e  r_state;
  gpio_drv_op_e     r_op;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_prev;
  logic [DLY_W-1:0] r_len;
  logic [WIDTH-1:0] r_gpio;
  logic             r_ready;
  logic             r_busy;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_prev;

  logic             w_accept;
  logic             w_tmr_load;
  logic [DLY_W-1:0] w_tmr_val;
  logic             w_expire;

  assign w_accept = cmd_valid && r_ready && (r_state == GPIO_DRV_IDLE);

  // One timer serves both phases: the delay is loaded at acceptance, the
  // pulse length (0 promoted to 1) at the APPLY edge of a PULSE.
  assign w_tmr_load = (w_accept && (cmd_delay != '0)) ||
                      ((r_state == GPIO_DRV_APPLY) && (r_op == GPIO_DRV_PULSE));
  assign w_tmr_val  = (r_state == GPIO_DRV_IDLE) ? cmd_delay :
                      ((r_len == '0) ? DLY_W'(1) : r_len);

  qcs_gpio_drv_timer #(
    .DLY_W (DLY_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= GPIO_DRV_IDLE;
      r_op        <= GPIO_DRV_WRITE;
      r_mask      <= '0;
      r_data      <= '0;
      r_prev      <= '0;
      r_len       <= '0;
      r_gpio      <= RESET_VAL;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_prev  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        GPIO_DRV_IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (w_accept) begin
            r_op    <= cmd_op;
            r_mask  <= cmd_mask;
            r_data  <= cmd_data;
            r_len   <= cmd_len;
            r_prev  <= r_gpio;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= (cmd_delay == '0) ? GPIO_DRV_APPLY : GPIO_DRV_WAIT;
          end
        end
        GPIO_DRV_WAIT: begin
          if (w_expire) begin
            r_state <= GPIO_DRV_APPLY;
          end
        end
        GPIO_DRV_APPLY: begin
          if (r_op == GPIO_DRV_PULSE) begin
            r_gpio  <= r_gpio | r_mask;
            r_state <= GPIO_DRV_HOLD;
          end else begin
            case (r_op)
              GPIO_DRV_WRITE: r_gpio <= (r_gpio & ~r_mask) | (r_data & r_mask);
              GPIO_DRV_SET:   r_gpio <= r_gpio | r_mask;
              default:        r_gpio <= r_gpio & ~r_mask;
            endcase
            r_rsp_valid <= 1'b1;
            r_rsp_prev  <= r_prev;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= GPIO_DRV_IDLE;
          end
        end
        default: begin
          // HOLD: restore masked bits from the captured pre-command state,
          // so bits that were already 1 stay 1.
          if (w_expire) begin
            r_gpio      <= (r_gpio & ~r_mask) | (r_prev & r_mask);
            r_rsp_valid <= 1'b1;
            r_rsp_prev  <= r_prev;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= GPIO_DRV_IDLE;
          end
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign gpio      = r_gpio;
  assign rsp_valid = r_rsp_valid;
  assign rsp_prev  = r_rsp_prev;

endmodule : qcs_gpio_drv
`default_nettype wire

// File: tb/tb_qcs_gpio_drv.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_qcs_gpio_drv
// Purpose : Self-checking bench for qcs_gpio_drv. Expected responses (prev
//           pins, final pins, completion cycle) are queued at command
//           acceptance and matched against each rsp_valid pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qcs_gpio_drv;
  import qcs_gpio_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  gpio_drv_op_e cmd_op = GPIO_DRV_WRITE;
  logic [7:0]   cmd_mask = '0;
  logic [7:0]   cmd_data = '0;
  logic [15:0]  cmd_delay = '0;
  logic [15:0]  cmd_len = '0;
  logic [7:0]   gpio;
  logic         rsp_valid;
  logic [7:0]   rsp_prev;
  logic         busy;

  qcs_gpio_drv #(.WIDTH(8), .DLY_W(16), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_data  (cmd_data),
    .cmd_delay (cmd_delay),
    .cmd_len   (cmd_len),
    .gpio      (gpio),
    .rsp_valid (rsp_valid),
    .rsp_prev  (rsp_prev),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] prev;
    logic [7:0] fin;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pushed = 0;
  int         n_rsp = 0;
  logic [7:0] m_gpio = 8'h00;
  int         last_e0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model(gpio_drv_op_e op, logic [7:0] g, logic [7:0] m, logic [7:0] d);
    case (op)
      GPIO_DRV_WRITE: return (g & ~m) | (d & m);
      GPIO_DRV_SET:   return g | m;
      GPIO_DRV_CLEAR: return g & ~m;
      default:        return g; // pulse restores to the pre-command value
    endcase
  endfunction

  // Response monitor: every rsp_valid must match the oldest queued entry.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_rsp++;
        chk("rsp_prev", {24'b0, rsp_prev}, {24'b0, e.prev});
        chk("rsp_gpio", {24'b0, gpio}, {24'b0, e.fin});
        chk("rsp_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic issue(input gpio_drv_op_e op, input logic [7:0] mask, input logic [7:0] data,
                       input logic [15:0] dly, input logic [15:0] len,
                       input bit expect_rsp, input bit hold_valid);
    int   n;
    exp_t e;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_data  = data;
    cmd_delay = dly;
    cmd_len   = len;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    last_e0 = cyc;
    if (!hold_valid) cmd_valid = 1'b0;
    if (expect_rsp) begin
      e.prev = m_gpio;
      e.fin  = model(op, m_gpio, mask, data);
      e.at   = last_e0 + int'(dly) + 1 + ((op == GPIO_DRV_PULSE) ? ((len == 0) ? 1 : int'(len)) : 0);
      sb.push_back(e);
      n_pushed++;
      m_gpio = e.fin;
    end
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] old;
    int         acc[4];

    // Reset state
    wait_n(3);
    chk("rst_gpio", {24'b0, gpio}, 32'h00);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_prev", {24'b0, rsp_prev}, 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, cmd_ready}, 32'd1);

    // SET 0x05, D=0
    issue(GPIO_DRV_SET, 8'h05, 8'h00, 16'd0, 16'd0, 1'b1, 1'b0);
    chk("set_ready_e0", {31'b0, cmd_ready}, 32'd0);
    chk("set_busy_e0", {31'b0, busy}, 32'd1);
    chk("set_gpio_e0", {24'b0, gpio}, 32'h00);
    wait_n(1);
    chk("set_gpio_e1", {24'b0, gpio}, 32'h05);
    chk("set_ready_e1", {31'b0, cmd_ready}, 32'd1);

    // WRITE 0x3C/0xAA over 0xF0 with D=3
    issue(GPIO_DRV_WRITE, 8'hFF, 8'hF0, 16'd0, 16'd0, 1'b1, 1'b0);
    wait_n(1);
    issue(GPIO_DRV_WRITE, 8'h3C, 8'hAA, 16'd3, 16'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      wait_n(1);
      chk("wr_gpio_hold", {24'b0, gpio}, 32'hF0);
    end
    wait_n(1);
    chk("wr_gpio_e4", {24'b0, gpio}, 32'hE8);

    // PULSE 0x81 over 0x01, L=5
    issue(GPIO_DRV_WRITE, 8'hFF, 8'h01, 16'd0, 16'd0, 1'b1, 1'b0);
    wait_n(1);
    issue(GPIO_DRV_PULSE, 8'h81, 8'h00, 16'd0, 16'd5, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      wait_n(1);
      chk("pulse_high", {24'b0, gpio}, 32'h81);
    end
    wait_n(1);
    chk("pulse_restore", {24'b0, gpio}, 32'h01);

    // PULSE with L=0 lasts one cycle
    issue(GPIO_DRV_PULSE, 8'h02, 8'h00, 16'd0, 16'd0, 1'b1, 1'b0);
    wait_n(1);
    chk("pulse0_high", {24'b0, gpio}, 32'h03);
    wait_n(1);
    chk("pulse0_restore", {24'b0, gpio}, 32'h01);

    // CLEAR with empty mask still responds
    issue(GPIO_DRV_CLEAR, 8'h00, 8'h00, 16'd0, 16'd0, 1'b1, 1'b0);
    wait_n(1);
    chk("clr0_gpio", {24'b0, gpio}, 32'h01);

    // Maximum delay
    issue(GPIO_DRV_SET, 8'h10, 8'h00, 16'hFFFF, 16'd0, 1'b1, 1'b0);
    wait_n(65535);
    chk("maxdly_before", {24'b0, gpio}, 32'h01);
    wait_n(1);
    chk("maxdly_after", {24'b0, gpio}, 32'h11);

    // Inputs toggled while busy have no effect
    old = m_gpio;
    issue(GPIO_DRV_WRITE, 8'hFF, 8'h5A, 16'd5, 16'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cmd_valid = 1'($urandom);
      cmd_op    = gpio_drv_op_e'($urandom_range(0, 3));
      cmd_mask  = 8'($urandom);
      cmd_data  = 8'($urandom);
      cmd_delay = 16'($urandom_range(0, 3));
      wait_n(1);
      chk("busy_gpio_hold", {24'b0, gpio}, {24'b0, old});
    end
    cmd_valid = 1'b0;
    wait_n(2);
    chk("busy_gpio_apply", {24'b0, gpio}, 32'h5A);

    // Reset in the middle of a PULSE (D=2, L=10)
    issue(GPIO_DRV_PULSE, 8'h0F, 8'h00, 16'd2, 16'd10, 1'b0, 1'b0);
    wait_n(5);
    chk("abort_pulse_high", {24'b0, gpio}, 32'h5F);
    rst_n = 1'b0;
    wait_n(1);
    chk("abort_gpio", {24'b0, gpio}, 32'h00);
    chk("abort_ready", {31'b0, cmd_ready}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    m_gpio = 8'h00;
    wait_n(1);
    rst_n = 1'b1;
    wait_n(1);
    chk("abort_ready_after", {31'b0, cmd_ready}, 32'd1);
    chk("abort_gpio_after", {24'b0, gpio}, 32'h00);

    // Back-to-back with cmd_valid held high
    for (int i = 0; i < 4; i++) begin
      issue(GPIO_DRV_SET, 8'(1 << i), 8'h00, 16'd0, 16'd0, 1'b1, (i < 3));
      acc[i] = last_e0;
    end
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 32'd2);
    wait_n(2);
    chk("b2b_gpio", {24'b0, gpio}, 32'h0F);

    wait_n(5);
    chk("sb_empty", sb.size(), 32'd0);
    chk("rsp_count", n_rsp, n_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
